eth_rx_frame_parser: RTL and testbench

- Byte-wide Ethernet receive parser sitting directly behind the GMII receive interface, ahead of the switch lookup and buffering stages.
- Strips preamble and SFD, then extracts DMAC, SMAC, up to LEVEL_OF_QTAG 802.1Q/802.1ad tags and the Ethertype.
- Streams the remaining bytes (payload plus FCS) downstream and reports per-frame length and error status.
- Frame format constants come from ethernet_pkg. There is no backpressure: GMII cannot stall.

---
 rtl/ethernet_pkg.sv | 18 +
 rtl/eth_rx_frame_parser.sv | 251 +++++++++++++++++++++++++
 tb/tb_eth_rx_frame_parser.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_pkg.sv
// Shared Ethernet frame-format constants for the receive datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ethernet_pkg;

  localparam int LEVEL_OF_QTAG           = 2;
  localparam int N_OF_BYTE_FRAME_MAX     = 1526;
  localparam int FRAME_SIZE_BIT_WIDTH    = 11;
  localparam int VLAN_ID_BIT_WIDTH       = 12;
  localparam int VLAN_PRIORITY_BIT_WIDTH = 3;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] C_VLAN_TPID   = 16'h8100;
  localparam logic [15:0] S_VLAN_TPID   = 16'h88A8;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_rx_frame_parser.sv
// Byte-wide GMII receive parser: strips preamble/SFD, extracts MACs, VLAN tags and Ethertype.
// Latency: header 2 cycles after last Ethertype byte; payload/frm_done 3 cycles after GMII input.
// Backpressure: none; GMII cannot stall, the consumer must accept every strobe.
//
// Ports:
//   clk, rst                      single clock, async active-high reset
//   gmii_rx_dv/er/rxd             raw GMII receive inputs
//   hdr_*                         parsed header, hdr_valid pulses once per frame, fields held
//   pld_valid/data/last           payload + FCS byte stream, pld_last on final FCS byte
//   frm_done, frm_len, frm_err_*  end-of-frame pulse with length and status flags
module eth_rx_frame_parser
  import ethernet_pkg::*;
#(
  parameter int MAX_TAGS        = LEVEL_OF_QTAG,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = N_OF_BYTE_FRAME_MAX,
  parameter int LEN_W           = FRAME_SIZE_BIT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               gmii_rx_dv,
  input  logic                               gmii_rx_er,
  input  logic [7:0]                         gmii_rxd,
  output logic                               hdr_valid,
  output logic [47:0]                        hdr_dmac,
  output logic [47:0]                        hdr_smac,
  output logic                               hdr_is_bcast,
  output logic [1:0]                         hdr_n_tags,
  output logic [VLAN_ID_BIT_WIDTH-1:0]       hdr_vid,
  output logic [VLAN_PRIORITY_BIT_WIDTH-1:0] hdr_pcp,
  output logic [15:0]                        hdr_ethertype,
  output logic                               pld_valid,
  output logic [7:0]                         pld_data,
  output logic                               pld_last,
  output logic                               frm_done,
  output logic [LEN_W-1:0]                   frm_len,
  output logic                               frm_err_runt,
  output logic                               frm_err_oversize,
  output logic                               frm_err_rx,
  output logic                               frm_err_trunc
);

  localparam logic [1:0]       MAX_TAGS_L = 2'(MAX_TAGS);
  localparam logic [LEN_W-1:0] MIN_LEN_L  = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN_L  = LEN_W'(MAX_FRAME_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DMAC, S_SMAC, S_TYPE, S_TAG, S_PAYLOAD, S_DROP
  } state_t;

  state_t state_q, state_d;

  // Registered GMII copy; the FSM only ever looks at these.
  logic       dv_q, er_q;
  logic [7:0] rxd_q;

  logic [2:0]  cnt_q;        // byte index within the current header field
  logic [7:0]  fld_q;        // first byte of a 2-byte TYPE/TCI field
  logic [47:0] dmac_sh_q, smac_sh_q;
  logic [1:0]  tags_q;
  logic [VLAN_ID_BIT_WIDTH-1:0]       ovid_q;
  logic [VLAN_PRIORITY_BIT_WIDTH-1:0] opcp_q;
  logic [LEN_W-1:0] len_q;
  logic [2:0]  pcnt_q;       // payload bytes seen, saturating at 4
  logic        err_rx_q;
  logic        hold_vld_q;
  logic [7:0]  hold_dat_q;

  logic                               hdr_valid_q, hdr_is_bcast_q;
  logic [47:0]                        hdr_dmac_q, hdr_smac_q;
  logic [1:0]                         hdr_n_tags_q;
  logic [VLAN_ID_BIT_WIDTH-1:0]       hdr_vid_q;
  logic [VLAN_PRIORITY_BIT_WIDTH-1:0] hdr_pcp_q;
  logic [15:0]                        hdr_ethertype_q;
  logic                               pld_valid_q, pld_last_q;
  logic [7:0]                         pld_data_q;
  logic                               frm_done_q;
  logic [LEN_W-1:0]                   frm_len_q;
  logic                               runt_q, over_q, rxe_q, trunc_q;

  logic        in_frame, end_frm, is_tpid, type_done, go_tag, hdr_fire, tag_done, sfd_hit;
  logic [15:0] type_val;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    in_frame  = (state_q == S_DMAC) || (state_q == S_SMAC) || (state_q == S_TYPE) ||
                (state_q == S_TAG)  || (state_q == S_PAYLOAD);
    end_frm   = in_frame && !dv_q;
    sfd_hit   = (state_q == S_PREAMBLE) && dv_q && (rxd_q == SFD_BYTE);
    type_val  = {fld_q, rxd_q};
    is_tpid   = (type_val == C_VLAN_TPID) || (type_val == S_VLAN_TPID);
    type_done = (state_q == S_TYPE) && dv_q && (cnt_q == 3'd1);
    // A TPID beyond the tag limit falls through and is reported as the Ethertype.
    go_tag    = type_done && is_tpid && (tags_q < MAX_TAGS_L);
    hdr_fire  = type_done && !go_tag;
    tag_done  = (state_q == S_TAG) && dv_q && (cnt_q == 3'd1);

    case (state_q)
      S_IDLE:
        if (dv_q) state_d = (rxd_q == PREAMBLE_BYTE) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE:
        if (!dv_q)                       state_d = S_IDLE;
        else if (rxd_q == SFD_BYTE)      state_d = S_DMAC;
        else if (rxd_q != PREAMBLE_BYTE) state_d = S_DROP;
      S_DMAC:
        if (!dv_q)               state_d = S_IDLE;
        else if (cnt_q == 3'd5)  state_d = S_SMAC;
      S_SMAC:
        if (!dv_q)               state_d = S_IDLE;
        else if (cnt_q == 3'd5)  state_d = S_TYPE;
      S_TYPE:
        if (!dv_q)         state_d = S_IDLE;
        else if (go_tag)   state_d = S_TAG;
        else if (hdr_fire) state_d = S_PAYLOAD;
      S_TAG:
        if (!dv_q)         state_d = S_IDLE;
        else if (tag_done) state_d = S_TYPE;
      S_PAYLOAD:
        if (!dv_q) state_d = S_IDLE;
      S_DROP:
        if (!dv_q) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dv_q            <= 1'b0;
      er_q            <= 1'b0;
      rxd_q           <= '0;
      cnt_q           <= '0;
      fld_q           <= '0;
      dmac_sh_q       <= '0;
      smac_sh_q       <= '0;
      tags_q          <= '0;
      ovid_q          <= '0;
      opcp_q          <= '0;
      len_q           <= '0;
      pcnt_q          <= '0;
      err_rx_q        <= 1'b0;
      hold_vld_q      <= 1'b0;
      hold_dat_q      <= '0;
      hdr_valid_q     <= 1'b0;
      hdr_dmac_q      <= '0;
      hdr_smac_q      <= '0;
      hdr_is_bcast_q  <= 1'b0;
      hdr_n_tags_q    <= '0;
      hdr_vid_q       <= '0;
      hdr_pcp_q       <= '0;
      hdr_ethertype_q <= '0;
      pld_valid_q     <= 1'b0;
      pld_data_q      <= '0;
      pld_last_q      <= 1'b0;
      frm_done_q      <= 1'b0;
      frm_len_q       <= '0;
      runt_q          <= 1'b0;
      over_q          <= 1'b0;
      rxe_q           <= 1'b0;
      trunc_q         <= 1'b0;
    end else begin
      dv_q  <= gmii_rx_dv;
      er_q  <= gmii_rx_er;
      rxd_q <= gmii_rxd;

      if (state_d != state_q) cnt_q <= '0;
      else if (dv_q)          cnt_q <= cnt_q + 3'd1;

      if (sfd_hit) begin
        len_q    <= '0;
        tags_q   <= '0;
        err_rx_q <= 1'b0;
      end

      if (in_frame && dv_q) begin
        if (len_q != '1) len_q <= len_q + LEN_W'(1);
        if (er_q)        err_rx_q <= 1'b1;
      end

      if (state_q == S_DMAC && dv_q) dmac_sh_q <= {dmac_sh_q[39:0], rxd_q};
      if (state_q == S_SMAC && dv_q) smac_sh_q <= {smac_sh_q[39:0], rxd_q};
      if ((state_q == S_TYPE || state_q == S_TAG) && dv_q) fld_q <= rxd_q;

      if (tag_done) begin
        tags_q <= tags_q + 2'd1;
        if (tags_q == 2'd0) begin
          opcp_q <= fld_q[7:5];
          ovid_q <= {fld_q[3:0], rxd_q};
        end
      end

      hdr_valid_q <= hdr_fire;
      if (hdr_fire) begin
        hdr_dmac_q      <= dmac_sh_q;
        hdr_smac_q      <= smac_sh_q;
        hdr_is_bcast_q  <= (dmac_sh_q == BCAST_MAC);
        hdr_n_tags_q    <= tags_q;
        // Outer-tag registers may be stale from an earlier frame when untagged.
        hdr_vid_q       <= (tags_q == 2'd0) ? '0 : ovid_q;
        hdr_pcp_q       <= (tags_q == 2'd0) ? '0 : opcp_q;
        hdr_ethertype_q <= type_val;
        pcnt_q          <= '0;
      end

      if (state_q == S_PAYLOAD && dv_q && pcnt_q != 3'd4) pcnt_q <= pcnt_q + 3'd1;

      // One-byte hold: a byte is released only once the next cycle shows
      // whether dv is still high, which is what decides pld_last.
      hold_vld_q <= (state_q == S_PAYLOAD) && dv_q;
      if (state_q == S_PAYLOAD && dv_q) hold_dat_q <= rxd_q;

      pld_valid_q <= hold_vld_q;
      pld_data_q  <= hold_vld_q ? hold_dat_q : 8'h00;
      pld_last_q  <= hold_vld_q && !dv_q;

      frm_done_q <= end_frm;
      if (end_frm) begin
        frm_len_q <= len_q;
        runt_q    <= (len_q < MIN_LEN_L);
        over_q    <= (len_q > MAX_LEN_L);
        rxe_q     <= err_rx_q;
        trunc_q   <= (state_q != S_PAYLOAD) || (pcnt_q < 3'd4);
      end
    end
  end

  assign hdr_valid        = hdr_valid_q;
  assign hdr_dmac         = hdr_dmac_q;
  assign hdr_smac         = hdr_smac_q;
  assign hdr_is_bcast     = hdr_is_bcast_q;
  assign hdr_n_tags       = hdr_n_tags_q;
  assign hdr_vid          = hdr_vid_q;
  assign hdr_pcp          = hdr_pcp_q;
  assign hdr_ethertype    = hdr_ethertype_q;
  assign pld_valid        = pld_valid_q;
  assign pld_data         = pld_data_q;
  assign pld_last         = pld_last_q;
  assign frm_done         = frm_done_q;
  assign frm_len          = frm_len_q;
  assign frm_err_runt     = runt_q;
  assign frm_err_oversize = over_q;
  assign frm_err_rx       = rxe_q;
  assign frm_err_trunc    = trunc_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser: one task per scenario, inline checks.
// Latency checked against GMII drive cycle: header +2, payload/frm_done +3.
// Backpressure: none; the monitor accepts every output strobe.
module tb_eth_rx_frame_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        hdr_valid, hdr_is_bcast;
  logic [47:0] hdr_dmac, hdr_smac;
  logic [1:0]  hdr_n_tags;
  logic [11:0] hdr_vid;
  logic [2:0]  hdr_pcp;
  logic [15:0] hdr_ethertype;
  logic        pld_valid, pld_last, frm_done;
  logic [7:0]  pld_data;
  logic [10:0] frm_len;
  logic        frm_err_runt, frm_err_oversize, frm_err_rx, frm_err_trunc;

  eth_rx_frame_parser dut (
    .clk(clk), .rst(rst),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .hdr_valid(hdr_valid), .hdr_dmac(hdr_dmac), .hdr_smac(hdr_smac),
    .hdr_is_bcast(hdr_is_bcast), .hdr_n_tags(hdr_n_tags), .hdr_vid(hdr_vid),
    .hdr_pcp(hdr_pcp), .hdr_ethertype(hdr_ethertype),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_last(pld_last),
    .frm_done(frm_done), .frm_len(frm_len),
    .frm_err_runt(frm_err_runt), .frm_err_oversize(frm_err_oversize),
    .frm_err_rx(frm_err_rx), .frm_err_trunc(frm_err_trunc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Frame under construction (DMAC through FCS) and drive cycle of each byte.
  logic [7:0] fb [0:2047];
  int         drv_cyc [0:2047];
  int         fb_len;

  // Output monitor, sampled on the falling edge.
  int         hdr_cnt, hdr_cyc, last_cnt, last_idx, last_cyc;
  logic [7:0] pld_q [$];
  int         done_cyc_q [$];
  int         done_len_q [$];
  logic [3:0] done_err_q [$];   // {runt, oversize, rx, trunc}
  logic       done_pv_q [$];

  always @(negedge clk) begin
    if (hdr_valid) begin
      hdr_cnt++;
      hdr_cyc = cyc;
    end
    if (pld_valid) begin
      pld_q.push_back(pld_data);
      if (pld_last) begin
        last_cnt++;
        last_idx = pld_q.size();
        last_cyc = cyc;
      end
    end
    if (frm_done) begin
      done_cyc_q.push_back(cyc);
      done_len_q.push_back(int'(frm_len));
      done_err_q.push_back({frm_err_runt, frm_err_oversize, frm_err_rx, frm_err_trunc});
      done_pv_q.push_back(pld_valid);
    end
  end

  task automatic clear_mon();
    hdr_cnt = 0; hdr_cyc = 0; last_cnt = 0; last_idx = 0; last_cyc = 0;
    pld_q.delete(); done_cyc_q.delete(); done_len_q.delete();
    done_err_q.delete(); done_pv_q.delete();
  endtask

  task automatic put8(input logic [7:0] b);
    fb[fb_len] = b;
    fb_len++;
  endtask

  task automatic put16(input logic [15:0] v);
    put8(v[15:8]);
    put8(v[7:0]);
  endtask

  task automatic put48(input logic [47:0] v);
    for (int i = 0; i < 6; i++) put8(v[47-8*i -: 8]);
  endtask

  task automatic put_pld(input int n);
    for (int i = 0; i < n; i++) put8(8'((i * 7 + 3) & 255));
  endtask

  task automatic mk_untagged(input logic [47:0] da, input logic [15:0] et, input int npld);
    fb_len = 0;
    put48(da);
    put48(48'h0200_0000_0001);
    put16(et);
    put_pld(npld);
  endtask

  task automatic drive_b(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    gmii_rx_dv = 1'b1; gmii_rxd = b; gmii_rx_er = e;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    end
  endtask

  task automatic send(input logic [7:0] sfd, input int er_idx, input int gap);
    for (int i = 0; i < 7; i++) drive_b(8'hAA, 1'b0);
    drive_b(sfd, 1'b0);
    for (int i = 0; i < fb_len; i++) begin
      drive_b(fb[i], i == er_idx);
      drv_cyc[i] = cyc;
    end
    idle(gap);
  endtask

  // Number of payload bytes that differ from fb starting at header offset hoff.
  function automatic int pld_mism(input int hoff);
    int m = 0;
    for (int i = 0; i < pld_q.size(); i++) if (pld_q[i] !== fb[hoff + i]) m++;
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (hdr_valid !== 1'b0) begin bad++; $display("FAIL rst_hdr_valid got=%b want=0", hdr_valid); end
    total++; if (pld_valid !== 1'b0) begin bad++; $display("FAIL rst_pld_valid got=%b want=0", pld_valid); end
    total++; if (frm_done !== 1'b0) begin bad++; $display("FAIL rst_frm_done got=%b want=0", frm_done); end
    total++; if (frm_len !== 11'd0) begin bad++; $display("FAIL rst_frm_len got=%0d want=0", frm_len); end
    total++; if (hdr_dmac !== 48'h0) begin bad++; $display("FAIL rst_hdr_dmac got=%h want=0", hdr_dmac); end
    total++; if ({frm_err_runt, frm_err_oversize, frm_err_rx, frm_err_trunc} !== 4'b0000) begin
      bad++; $display("FAIL rst_err got=%b want=0000", {frm_err_runt, frm_err_oversize, frm_err_rx, frm_err_trunc}); end
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_untagged();
    mk_untagged(48'hFFFF_FFFF_FFFF, 16'h0800, 50);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (hdr_cnt !== 1) begin bad++; $display("FAIL unt_hdr_cnt got=%0d want=1", hdr_cnt); end
    total++; if (hdr_cyc !== drv_cyc[13] + 2) begin bad++; $display("FAIL unt_hdr_lat got=%0d want=%0d", hdr_cyc, drv_cyc[13] + 2); end
    total++; if (hdr_is_bcast !== 1'b1) begin bad++; $display("FAIL unt_bcast got=%b want=1", hdr_is_bcast); end
    total++; if (hdr_n_tags !== 2'd0) begin bad++; $display("FAIL unt_ntags got=%0d want=0", hdr_n_tags); end
    total++; if (hdr_ethertype !== 16'h0800) begin bad++; $display("FAIL unt_etype got=%h want=0800", hdr_ethertype); end
    total++; if (hdr_smac !== 48'h0200_0000_0001) begin bad++; $display("FAIL unt_smac got=%h want=020000000001", hdr_smac); end
    total++; if ({hdr_pcp, hdr_vid} !== 15'd0) begin bad++; $display("FAIL unt_vlan got=%h want=0", {hdr_pcp, hdr_vid}); end
    total++; if (pld_q.size() !== 50) begin bad++; $display("FAIL unt_pld_cnt got=%0d want=50", pld_q.size()); end
    total++; if (pld_mism(14) !== 0) begin bad++; $display("FAIL unt_pld_data got=%0d bad bytes want=0", pld_mism(14)); end
    total++; if (last_cnt !== 1 || last_idx !== 50) begin bad++; $display("FAIL unt_last got cnt=%0d idx=%0d want 1/50", last_cnt, last_idx); end
    total++; if (last_cyc !== drv_cyc[63] + 3) begin bad++; $display("FAIL unt_last_lat got=%0d want=%0d", last_cyc, drv_cyc[63] + 3); end
    total++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== drv_cyc[63] + 3) begin
      bad++; $display("FAIL unt_done got n=%0d cyc=%0d want 1/%0d", done_cyc_q.size(), done_cyc_q[0], drv_cyc[63] + 3); end
    total++; if (done_len_q[0] !== 64) begin bad++; $display("FAIL unt_len got=%0d want=64", done_len_q[0]); end
    total++; if (done_err_q[0] !== 4'b0000) begin bad++; $display("FAIL unt_err got=%b want=0000", done_err_q[0]); end
  endtask

  task automatic test_double_tag();
    fb_len = 0;
    put48(48'h0A0B_0C0D_0E0F); put48(48'h0200_0000_0002);
    put16(16'h88A8); put16(16'hA00A); put16(16'h8100); put16(16'h0064); put16(16'h86DD);
    put_pld(50);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (hdr_cnt !== 1) begin bad++; $display("FAIL dt_hdr_cnt got=%0d want=1", hdr_cnt); end
    total++; if (hdr_n_tags !== 2'd2) begin bad++; $display("FAIL dt_ntags got=%0d want=2", hdr_n_tags); end
    total++; if (hdr_pcp !== 3'd5) begin bad++; $display("FAIL dt_pcp got=%0d want=5", hdr_pcp); end
    total++; if (hdr_vid !== 12'd10) begin bad++; $display("FAIL dt_vid got=%0d want=10", hdr_vid); end
    total++; if (hdr_ethertype !== 16'h86DD) begin bad++; $display("FAIL dt_etype got=%h want=86dd", hdr_ethertype); end
    total++; if (hdr_is_bcast !== 1'b0) begin bad++; $display("FAIL dt_bcast got=%b want=0", hdr_is_bcast); end
    total++; if (hdr_dmac !== 48'h0A0B_0C0D_0E0F) begin bad++; $display("FAIL dt_dmac got=%h want=0a0b0c0d0e0f", hdr_dmac); end
    total++; if (pld_q.size() !== 50 || pld_mism(22) !== 0) begin bad++; $display("FAIL dt_pld got n=%0d mism=%0d want 50/0", pld_q.size(), pld_mism(22)); end
    total++; if (done_len_q[0] !== 72 || done_err_q[0] !== 4'b0000) begin
      bad++; $display("FAIL dt_done got len=%0d err=%b want 72/0000", done_len_q[0], done_err_q[0]); end
  endtask

  task automatic test_triple_tpid();
    fb_len = 0;
    put48(48'h0A0B_0C0D_0E0F); put48(48'h0200_0000_0003);
    put16(16'h88A8); put16(16'h6123); put16(16'h8100); put16(16'h0456); put16(16'h8100);
    put_pld(46);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (hdr_ethertype !== 16'h8100) begin bad++; $display("FAIL tt_etype got=%h want=8100", hdr_ethertype); end
    total++; if (hdr_n_tags !== 2'd2) begin bad++; $display("FAIL tt_ntags got=%0d want=2", hdr_n_tags); end
    total++; if (hdr_vid !== 12'h123 || hdr_pcp !== 3'd3) begin bad++; $display("FAIL tt_outer got vid=%h pcp=%0d want 123/3", hdr_vid, hdr_pcp); end
    total++; if (pld_q.size() !== 46 || pld_mism(22) !== 0) begin bad++; $display("FAIL tt_pld got n=%0d mism=%0d want 46/0", pld_q.size(), pld_mism(22)); end
    total++; if (done_len_q[0] !== 68 || done_err_q[0] !== 4'b0000) begin
      bad++; $display("FAIL tt_done got len=%0d err=%b want 68/0000", done_len_q[0], done_err_q[0]); end
  endtask

  task automatic test_sizes();
    mk_untagged(48'h0A0B_0C0D_0E0F, 16'h0800, 1516);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (done_len_q[0] !== 1530 || done_err_q[0] !== 4'b0100) begin
      bad++; $display("FAIL big_done got len=%0d err=%b want 1530/0100", done_len_q[0], done_err_q[0]); end
    total++; if (pld_q.size() !== 1516) begin bad++; $display("FAIL big_pld got=%0d want=1516", pld_q.size()); end

    mk_untagged(48'h0A0B_0C0D_0E0F, 16'h0800, 26);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (done_len_q[0] !== 40 || done_err_q[0] !== 4'b1000) begin
      bad++; $display("FAIL runt_done got len=%0d err=%b want 40/1000", done_len_q[0], done_err_q[0]); end

    fb_len = 0;
    put48(48'h0A0B_0C0D_0E0F); put8(8'h02); put8(8'h00); put8(8'h00); put8(8'h00);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (hdr_cnt !== 0) begin bad++; $display("FAIL trunc_hdr got=%0d want=0", hdr_cnt); end
    total++; if (done_len_q.size() !== 1 || done_len_q[0] !== 10 || done_err_q[0] !== 4'b1001) begin
      bad++; $display("FAIL trunc_done got n=%0d len=%0d err=%b want 1/10/1001", done_len_q.size(), done_len_q[0], done_err_q[0]); end
    total++; if (done_cyc_q[0] !== drv_cyc[9] + 3 || done_pv_q[0] !== 1'b0 || pld_q.size() !== 0) begin
      bad++; $display("FAIL trunc_timing got cyc=%0d pv=%b pld=%0d want %0d/0/0", done_cyc_q[0], done_pv_q[0], pld_q.size(), drv_cyc[9] + 3); end

    // Ethertype complete but fewer than 4 trailing bytes.
    mk_untagged(48'h0A0B_0C0D_0E0F, 16'h0800, 2);
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (hdr_cnt !== 1 || pld_q.size() !== 2) begin bad++; $display("FAIL short_hdr_pld got hdr=%0d pld=%0d want 1/2", hdr_cnt, pld_q.size()); end
    total++; if (done_len_q[0] !== 16 || done_err_q[0] !== 4'b1001) begin
      bad++; $display("FAIL short_done got len=%0d err=%b want 16/1001", done_len_q[0], done_err_q[0]); end
  endtask

  task automatic test_rx_err();
    mk_untagged(48'h0A0B_0C0D_0E0F, 16'h0800, 50);
    clear_mon();
    send(8'hD5, 30, 8);
    total++; if (done_err_q[0] !== 4'b0010 || done_len_q[0] !== 64) begin
      bad++; $display("FAIL rxer_done got len=%0d err=%b want 64/0010", done_len_q[0], done_err_q[0]); end
    total++; if (pld_q.size() !== 50 || last_idx !== 50 || pld_mism(14) !== 0) begin
      bad++; $display("FAIL rxer_pld got n=%0d last=%0d mism=%0d want 50/50/0", pld_q.size(), last_idx, pld_mism(14)); end
  endtask

  task automatic test_bad_sfd();
    mk_untagged(48'h0A0B_0C0D_0E0F, 16'h0800, 50);
    clear_mon();
    send(8'h55, -1, 8);
    total++; if (done_cyc_q.size() !== 0 || pld_q.size() !== 0 || hdr_cnt !== 0) begin
      bad++; $display("FAIL badsfd got done=%0d pld=%0d hdr=%0d want 0/0/0", done_cyc_q.size(), pld_q.size(), hdr_cnt); end
  endtask

  task automatic test_mid_reset();
    mk_untagged(48'hFFFF_FFFF_FFFF, 16'h0800, 50);
    for (int i = 0; i < 7; i++) drive_b(8'hAA, 1'b0);
    drive_b(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive_b(fb[i], 1'b0);
    total++; if (pld_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre_pld got=%b want=1", pld_valid); end
    rst = 1'b1;
    #1;
    total++; if (pld_valid !== 1'b0 || hdr_is_bcast !== 1'b0) begin
      bad++; $display("FAIL mrst_clear got pv=%b bc=%b want 0/0", pld_valid, hdr_is_bcast); end
    total++; if (hdr_dmac !== 48'h0 || frm_len !== 11'd0) begin
      bad++; $display("FAIL mrst_fields got dmac=%h len=%0d want 0/0", hdr_dmac, frm_len); end
    clear_mon();
    for (int i = 0; i < 3; i++) drive_b(8'h11, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) drive_b(8'h11, 1'b0);
    idle(8);
    total++; if (hdr_cnt !== 0 || pld_q.size() !== 0 || done_cyc_q.size() !== 0) begin
      bad++; $display("FAIL mrst_quiet got hdr=%0d pld=%0d done=%0d want 0/0/0", hdr_cnt, pld_q.size(), done_cyc_q.size()); end
    clear_mon();
    send(8'hD5, -1, 8);
    total++; if (hdr_cnt !== 1 || hdr_ethertype !== 16'h0800 || hdr_is_bcast !== 1'b1) begin
      bad++; $display("FAIL mrst_fresh_hdr got n=%0d et=%h bc=%b want 1/0800/1", hdr_cnt, hdr_ethertype, hdr_is_bcast); end
    total++; if (done_len_q[0] !== 64 || done_err_q[0] !== 4'b0000 || pld_q.size() !== 50) begin
      bad++; $display("FAIL mrst_fresh_done got len=%0d err=%b pld=%0d want 64/0000/50", done_len_q[0], done_err_q[0], pld_q.size()); end
  endtask

  task automatic test_back_to_back();
    int a_last;
    clear_mon();
    mk_untagged(48'h0A0B_0C0D_0E0F, 16'h0800, 50);
    send(8'hD5, -1, 1);
    a_last = drv_cyc[63];
    mk_untagged(48'hFFFF_FFFF_FFFF, 16'h88F7, 54);
    send(8'hD5, -1, 8);
    total++; if (done_len_q.size() !== 2) begin bad++; $display("FAIL b2b_ndone got=%0d want=2", done_len_q.size()); end
    total++; if (done_cyc_q[0] !== a_last + 3) begin bad++; $display("FAIL b2b_done0_lat got=%0d want=%0d", done_cyc_q[0], a_last + 3); end
    total++; if (done_len_q[0] !== 64 || done_len_q[1] !== 68) begin
      bad++; $display("FAIL b2b_len got=%0d,%0d want 64,68", done_len_q[0], done_len_q[1]); end
    total++; if (done_err_q[0] !== 4'b0000 || done_err_q[1] !== 4'b0000) begin
      bad++; $display("FAIL b2b_err got=%b,%b want 0000,0000", done_err_q[0], done_err_q[1]); end
    total++; if (hdr_cnt !== 2 || hdr_ethertype !== 16'h88F7) begin
      bad++; $display("FAIL b2b_hdr got n=%0d et=%h want 2/88f7", hdr_cnt, hdr_ethertype); end
    total++; if (pld_q.size() !== 104 || last_cnt !== 2) begin
      bad++; $display("FAIL b2b_pld got n=%0d last=%0d want 104/2", pld_q.size(), last_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_untagged();
    test_double_tag();
    test_triple_tpid();
    test_sizes();
    test_rx_err();
    test_bad_sfd();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
